pwm_capture: RTL and testbench

PWM capture block: the receive-side counterpart of the team's PWM generator. It samples an asynchronous PWM input and measures period and high time in clock cycles. It publishes each completed measurement with a one-cycle valid strobe and flags timeouts for constant-level inputs, such as 0 % or 100 % duty. It sits on the chip input side, feeding measured values to control logic or loopback checks of the generator.

---
 rtl/pwm_capture.sv | 169 ++++++++++++++++
 tb/tb_pwm_capture.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_capture.sv
// PWM capture: synchronizes pwm_i and measures rise-to-rise period and rise-to-fall high time.
// Optional glitch filter on the synchronized level: define PWM_CAP_GLITCH_FILTER_EN.
`timescale 1ns/1ps

module pwm_capture #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             res_ni,
    input  logic             ena,
    input  logic             pwm_i,
    output logic [CNT_W-1:0] period_o,
    output logic [CNT_W-1:0] high_o,
    output logic             valid_o,
    output logic             timeout_o,
    output logic             level_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    logic             r_s1;
    logic             r_s2;
    logic             r_s3;
    logic             w_lvl;
    logic             w_rise;
    logic             w_fall;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] r_hi_lat;
    logic [CNT_W-1:0] w_hi_lat_nxt;
    logic [CNT_W-1:0] w_period_nxt;
    logic [CNT_W-1:0] w_high_nxt;
    logic             w_valid_nxt;
    logic             w_timeout_nxt;

`ifdef PWM_CAP_GLITCH_FILTER_EN
    logic [1:0] r_stab;

    // Filtered level flips in the third consecutive cycle s2 disagrees with it.
    always_comb begin
        if ((r_s2 != r_s3) && (r_stab == 2'd2)) begin
            w_lvl = r_s2;
        end else begin
            w_lvl = r_s3;
        end
    end

    // Counts consecutive cycles of disagreement between s2 and the filtered level.
    always_ff @(posedge clk or negedge res_ni) begin
        if (!res_ni) begin
            r_stab <= 2'd0;
        end else if ((r_s2 == r_s3) || (r_stab == 2'd2)) begin
            r_stab <= 2'd0;
        end else begin
            r_stab <= r_stab + 2'd1;
        end
    end
`else
    assign w_lvl = r_s2;
`endif

    assign w_rise  = w_lvl & ~r_s3;
    assign w_fall  = ~w_lvl & r_s3;
    assign level_o = r_s3;

    // Two-flop synchronizer plus history flop holding the (filtered) level.
    always_ff @(posedge clk or negedge res_ni) begin
        if (!res_ni) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= pwm_i;
            r_s2 <= r_s1;
            r_s3 <= w_lvl;
        end
    end

    // Measurement FSM; a saturated counter abandons the measurement without touching results.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_hi_lat_nxt  = r_hi_lat;
        w_period_nxt  = period_o;
        w_high_nxt    = high_o;
        w_valid_nxt   = 1'b0;
        w_timeout_nxt = 1'b0;
        if (!ena) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = CNT_ZERO;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_rise) begin
                        w_state_nxt = ST_HIGH;
                        w_cnt_nxt   = CNT_ONE;
                    end else begin
                        w_cnt_nxt   = CNT_ZERO;
                    end
                end
                ST_HIGH: begin
                    if (w_fall) begin
                        w_hi_lat_nxt = r_cnt;
                        w_cnt_nxt    = r_cnt + CNT_ONE;
                        w_state_nxt  = ST_LOW;
                    end else if (r_cnt == CNT_MAX) begin
                        w_timeout_nxt = 1'b1;
                        w_state_nxt   = ST_IDLE;
                        w_cnt_nxt     = CNT_ZERO;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_ONE;
                    end
                end
                ST_LOW: begin
                    if (w_rise) begin
                        w_period_nxt = r_cnt;
                        w_high_nxt   = r_hi_lat;
                        w_valid_nxt  = 1'b1;
                        w_cnt_nxt    = CNT_ONE;
                        w_state_nxt  = ST_HIGH;
                    end else if (r_cnt == CNT_MAX) begin
                        w_timeout_nxt = 1'b1;
                        w_state_nxt   = ST_IDLE;
                        w_cnt_nxt     = CNT_ZERO;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_ONE;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = CNT_ZERO;
                end
            endcase
        end
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk or negedge res_ni) begin
        if (!res_ni) begin
            r_state   <= ST_IDLE;
            r_cnt     <= CNT_ZERO;
            r_hi_lat  <= CNT_ZERO;
            period_o  <= CNT_ZERO;
            high_o    <= CNT_ZERO;
            valid_o   <= 1'b0;
            timeout_o <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_hi_lat  <= w_hi_lat_nxt;
            period_o  <= w_period_nxt;
            high_o    <= w_high_nxt;
            valid_o   <= w_valid_nxt;
            timeout_o <= w_timeout_nxt;
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// Scoreboard bench for pwm_capture: two instances (16-bit and 4-bit counters) share stimulus
// and are checked against a timestamp-based reference model.
`timescale 1ns/1ps

module tb_pwm_capture;

    logic        clk = 1'b0;
    logic        res_ni = 1'b0;
    logic        ena = 1'b0;
    logic        pwm_i = 1'b0;
    logic [15:0] per0, hi0;
    logic        v0, t0, l0;
    logic [3:0]  per1, hi1;
    logic        v1, t1, l1;

    always #5 clk = ~clk;

    pwm_capture #(.CNT_W(16)) dut16 (
        .clk(clk), .res_ni(res_ni), .ena(ena), .pwm_i(pwm_i),
        .period_o(per0), .high_o(hi0), .valid_o(v0), .timeout_o(t0), .level_o(l0)
    );

    pwm_capture #(.CNT_W(4)) dut4 (
        .clk(clk), .res_ni(res_ni), .ena(ena), .pwm_i(pwm_i),
        .period_o(per1), .high_o(hi1), .valid_o(v1), .timeout_o(t1), .level_o(l1)
    );

    typedef struct {
        int at;
        bit to;
        int per;
        int hi;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    bit started = 1'b0;

    // Reference model: phase 0 = waiting for a rise, 1 = high part, 2 = low part.
    int ph[2];
    int t_rise[2];
    int t_fall[2];
    int lp_per[2];
    int lp_hi[2];
    int held_per[2];
    int held_hi[2];
    logic h0 = 1'b0, h1 = 1'b0, h2 = 1'b0, h3 = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0d, want %0d", name, cyc, act, exp);
        end
    endtask

    task automatic push(input int d, input bit to);
        exp_t it;
        it.at  = cyc + 1;
        it.to  = to;
        it.per = lp_per[d];
        it.hi  = lp_hi[d];
        if (d == 0) q0.push_back(it);
        else q1.push_back(it);
    endtask

    // Edges of the delayed level; results are differences of edge timestamps.
    task automatic model_step(input int d, input int maxv, input logic lv, input logic pv, input logic e);
        logic rise, fall;
        rise = lv & ~pv;
        fall = ~lv & pv;
        if (!e) begin
            ph[d] = 0;
        end else if (ph[d] == 1) begin
            if (fall) begin
                t_fall[d] = cyc;
                ph[d] = 2;
            end else if (cyc - t_rise[d] == maxv) begin
                ph[d] = 0;
                push(d, 1'b1);
            end
        end else if (ph[d] == 2) begin
            if (rise) begin
                lp_per[d] = cyc - t_rise[d];
                lp_hi[d]  = t_fall[d] - t_rise[d];
                push(d, 1'b0);
                t_rise[d] = cyc;
                ph[d] = 1;
            end else if (cyc - t_rise[d] == maxv) begin
                ph[d] = 0;
                push(d, 1'b1);
            end
        end else if (rise) begin
            t_rise[d] = cyc;
            ph[d] = 1;
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            ph[d] = 0; t_rise[d] = 0; t_fall[d] = 0;
            lp_per[d] = 0; lp_hi[d] = 0; held_per[d] = 0; held_hi[d] = 0;
        end
        q0.delete();
        q1.delete();
        h0 = 1'b0; h1 = 1'b0; h2 = 1'b0; h3 = 1'b0;
    endtask

    task automatic step(input logic v, input logic e);
        @(posedge clk);
        #1;
        pwm_i = v;
        ena = e;
        h3 = h2; h2 = h1; h1 = h0; h0 = v;
        model_step(0, 65535, h2, h3, e);
        model_step(1, 15, h2, h3, e);
    endtask

    task automatic seg(input int hi, input int lo, input int n);
        for (int k = 0; k < n; k++) begin
            for (int i = 0; i < hi; i++) step(1'b1, 1'b1);
            for (int i = 0; i < lo; i++) step(1'b0, 1'b1);
        end
    endtask

    task automatic mon(input int d, input logic v, input logic t, input logic [15:0] per,
                       input logic [15:0] hi, input logic l);
        exp_t it;
        bit have;
        chk("level", l, h3);
        have = 1'b0;
        while (!have) begin
            if (d == 0 && q0.size() > 0 && q0[0].at < cyc) begin
                it = q0.pop_front();
                chk("strobe_missing", cyc, it.at);
            end else if (d == 1 && q1.size() > 0 && q1[0].at < cyc) begin
                it = q1.pop_front();
                chk("strobe_missing", cyc, it.at);
            end else begin
                have = 1'b1;
            end
        end
        if (v || t) begin
            if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                chk("unexpected_strobe", {v, t}, 2'b00);
            end else begin
                if (d == 0) it = q0.pop_front();
                else it = q1.pop_front();
                chk("strobe_time", cyc, it.at);
                chk("timeout_flag", t, it.to);
                chk("valid_flag", v, !it.to);
                chk("period", per, it.per);
                chk("high", hi, it.hi);
                held_per[d] = it.per;
                held_hi[d]  = it.hi;
            end
        end else begin
            chk("period_held", per, held_per[d]);
            chk("high_held", hi, held_hi[d]);
        end
    endtask

    // Monitor: pops the scoreboard whenever a DUT presents a strobe.
    always @(negedge clk) begin
        if (res_ni && started) begin
            mon(0, v0, t0, per0, hi0, l0);
            mon(1, v1, t1, {12'd0, per1}, {12'd0, hi1}, l1);
        end
    end

    task automatic chk_zero(input string tag);
        chk({tag, "_per16"}, per0, 0);
        chk({tag, "_hi16"}, hi0, 0);
        chk({tag, "_flags16"}, {v0, t0, l0}, 0);
        chk({tag, "_per4"}, per1, 0);
        chk({tag, "_hi4"}, hi1, 0);
        chk({tag, "_flags4"}, {v1, t1, l1}, 0);
    endtask

    function automatic int pick_len();
        if ($urandom_range(0, 9) == 0) return int'($urandom_range(16, 22));
        return int'($urandom_range(1, 13));
    endfunction

    initial begin
        #100000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int hl, ll;
        model_reset();
        #12;
        chk_zero("reset");
        @(posedge clk);
        #2 res_ni = 1'b1;
        started = 1'b1;

        for (int i = 0; i < 4; i++) step(1'b0, 1'b1);
        seg(3, 7, 6);
        seg(8, 2, 4);

        // ena dropped in the low part of a period
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
        for (int i = 0; i < 2; i++) step(1'b0, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
        seg(3, 7, 3);

        // stuck high, then stuck low: the 4-bit instance saturates
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1);
        seg(2, 4, 4);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1);
        seg(3, 7, 2);

        // one-cycle glitch in the low part of a 10/10 signal
        seg(10, 10, 2);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1);
        seg(10, 10, 2);

        // reset in the high part of a measurement
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1);
        @(posedge clk);
        #3 res_ni = 1'b0;
        #1 chk_zero("midreset");
        pwm_i = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #2 res_ni = 1'b1;
        seg(3, 7, 3);

        for (int s = 0; s < 150; s++) begin
            hl = pick_len();
            ll = pick_len();
            for (int i = 0; i < hl; i++) step(1'b1, 1'b1);
            if ($urandom_range(0, 19) == 0) begin
                for (int i = 0; i < ll; i++) step(1'b0, (i % 4) != 1);
            end else begin
                for (int i = 0; i < ll; i++) step(1'b0, 1'b1);
            end
        end

        for (int i = 0; i < 6; i++) step(1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("pending16", q0.size(), 0);
        chk("pending4", q1.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
